display_frame_scheduler: RTL

//  Sequences the combinational garbled display datapath (rndswitch/segment2pixel chain) over N frames.
//  - Latches msg/z once per job.
//  - Fetches one fresh RNDSIZE seed per frame from an entropy stream.
//  - Drives the datapath, waits its settle latency, registers pix and hands it to a consumer via valid/ready.

---
 rtl/display_pkg.sv | 16 +
 rtl/display_frame_scheduler_out_reg.sv | 38 +++
 rtl/display_frame_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types for the garbled display frame scheduler.
// Holds the control FSM encoding and default display geometry.
package display_pkg;

    localparam int WIDTH_DEF  = 56;
    localparam int HEIGHT_DEF = 24;
    localparam int PIX_W      = WIDTH_DEF * HEIGHT_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETTLE,
        ST_PRESENT
    } sched_state_t;

endpackage

// File: rtl/display_frame_scheduler_out_reg.sv
// Frame holding register: keeps pix_out/pix_valid stable until the
// consumer accepts; flush drops a pending frame immediately.
module frame_out_reg
    import display_pkg::*;
#(
    parameter int PW = PIX_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [PW-1:0] i_pix,
    input  logic          i_ready,
    input  logic          i_flush,
    output logic [PW-1:0] o_pix,
    output logic          o_valid
);

    logic [PW-1:0] r_pix;
    logic          r_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pix   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pix   <= i_pix;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_pix   = r_pix;
    assign o_valid = r_valid;

endmodule

// File: rtl/display_frame_scheduler.sv
// Sequences the combinational garbled display datapath over N frames.
// Define FRAME_SCHED_WATERMARK_EN to add the per-job watermark plane.
module display_frame_scheduler
    import display_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int NB_SEGMENTS = 28,
    parameter int RNDSIZE     = 16,
    parameter int DP_LATENCY  = 2,
    parameter int FCNT_W      = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [FCNT_W-1:0]         i_cfg_frames,
    input  logic [NB_SEGMENTS-1:0]    i_cfg_msg,
    input  logic                      i_cfg_z,
    input  logic [RNDSIZE-1:0]        i_rnd_in,
    input  logic                      i_rnd_valid,
    output logic                      o_rnd_ready,
    output logic [NB_SEGMENTS-1:0]    o_dp_msg,
    output logic                      o_dp_z,
    output logic [RNDSIZE-1:0]        o_dp_rnd,
    input  logic [WIDTH*HEIGHT-1:0]   i_dp_pix,
    output logic [WIDTH*HEIGHT-1:0]   o_pix_out,
    output logic                      o_pix_valid,
    input  logic                      i_pix_ready,
    output logic                      o_busy,
    output logic                      o_done,
`ifdef FRAME_SCHED_WATERMARK_EN
    input  logic [WIDTH*HEIGHT-1:0]   i_cfg_watmk,
    output logic [WIDTH*HEIGHT-1:0]   o_dp_watmk,
`endif
    input  logic                      i_abort
);

    localparam int PW    = WIDTH * HEIGHT;
    localparam int CNT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

    sched_state_t               r_state;
    logic [NB_SEGMENTS-1:0]     r_msg;
    logic                       r_z;
    logic [RNDSIZE-1:0]         r_rnd;
    logic [FCNT_W-1:0]          r_remaining;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_done;

    logic                       w_pix_valid;
    logic                       w_pix_hs;
    logic                       w_load;
    logic                       w_flush;

    assign w_pix_hs = (r_state == ST_PRESENT) && w_pix_valid && i_pix_ready;
    assign w_load   = (r_state == ST_SETTLE) && (r_cnt == '0);
    assign w_flush  = i_abort && (r_state != ST_IDLE);

    // Abort outranks every state action, including a same-cycle handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_msg       <= '0;
            r_z         <= 1'b0;
            r_rnd       <= '0;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_flush) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
                r_rnd   <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (i_cfg_frames != '0) begin
                                r_msg       <= i_cfg_msg;
                                r_z         <= i_cfg_z;
                                r_remaining <= i_cfg_frames;
                                r_state     <= ST_FETCH;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (i_rnd_valid) begin
                            r_rnd   <= i_rnd_in;
                            r_cnt   <= CNT_W'(DP_LATENCY - 1);
                            r_state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_PRESENT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_PRESENT: begin
                        if (w_pix_hs) begin
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == FCNT_W'(1)) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FRAME_SCHED_WATERMARK_EN
    logic [PW-1:0] r_watmk;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_watmk <= '0;
        end else if (r_state == ST_IDLE && i_start && i_cfg_frames != '0) begin
            r_watmk <= i_cfg_watmk;
        end
    end

    assign o_dp_watmk = r_watmk;
`endif

    frame_out_reg #(
        .PW (PW)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_pix   (i_dp_pix),
        .i_ready (i_pix_ready),
        .i_flush (w_flush),
        .o_pix   (o_pix_out),
        .o_valid (w_pix_valid)
    );

    assign o_pix_valid = w_pix_valid;
    assign o_rnd_ready = (r_state == ST_FETCH);
    assign o_dp_msg    = r_msg;
    assign o_dp_z      = r_z;
    assign o_dp_rnd    = r_rnd;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;

endmodule
